// File: rtl/quadrature_decoder_if.sv
// rtl/quadrature_decoder_if.sv - quadrature decoder channel/control/status bundle (QDEC_INDEX_EN adds idx_in)
interface quadrature_decoder_if #(
  parameter int N = 16
);
  logic         a_in;
  logic         b_in;
  logic         pos_clr;
  logic         err_clr;
`ifdef QDEC_INDEX_EN
  logic         idx_in;
`endif
  logic         step;
  logic         up;
  logic         err;
  logic [N-1:0] pos;

`ifdef QDEC_INDEX_EN
  modport master (output a_in, b_in, pos_clr, err_clr, idx_in, input step, up, err, pos);
  modport slave  (input a_in, b_in, pos_clr, err_clr, idx_in, output step, up, err, pos);
`else
  modport master (output a_in, b_in, pos_clr, err_clr, input step, up, err, pos);
  modport slave  (input a_in, b_in, pos_clr, err_clr, output step, up, err, pos);
`endif
endinterface

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - filtered quadrature decoder with position counter; QDEC_INDEX_EN compiles in the index clear
module quadrature_decoder #(
  parameter int N    = 16,
  parameter int FILT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  quadrature_decoder_if.slave  bus
);

  // Channel 0 = A, 1 = B, 2 = index (only when the index feature is built).
`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] f_q;
  logic [NCH-1:0] prev_q;
  logic [3:0]     cnt_q [NCH];

  state_t         state_q;
  logic [1:0]     init_cnt_q;
  logic           step_q;
  logic           up_q;
  logic           err_q;
  logic [N-1:0]   pos_q;

  logic [1:0]     ab_prev;
  logic [1:0]     ab_cur;
  logic           move_d;
  logic           fwd_d;
  logic           ill_d;
  logic           idx_rise_d;
  logic [N-1:0]   pos_d;

  assign raw[0] = bus.a_in;
  assign raw[1] = bus.b_in;
`ifdef QDEC_INDEX_EN
  assign raw[2] = bus.idx_in;
`endif

  // Two-flop synchronizers and per-channel persistence filters; filters idle in INIT and preload on its last edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      f_q  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      if (state_q == S_INIT) begin
        for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        if (init_cnt_q == 2'd2) f_q <= s2_q;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (s2_q[i] == f_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == 4'(FILT - 1)) begin
            f_q[i]   <= s2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  assign ab_prev = {prev_q[0], prev_q[1]};
  assign ab_cur  = {f_q[0], f_q[1]};

`ifdef QDEC_INDEX_EN
  assign idx_rise_d = f_q[2] & ~prev_q[2];
`else
  assign idx_rise_d = 1'b0;
`endif

  // Classify the filtered {A,B} change and form the next position (clear beats index beats step).
  always_comb begin
    move_d = 1'b0;
    fwd_d  = 1'b0;
    ill_d  = 1'b0;
    case ({ab_prev, ab_cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
        move_d = 1'b1;
        fwd_d  = 1'b1;
      end
      4'b0001, 4'b0111, 4'b1110, 4'b1000: move_d = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: ill_d  = 1'b1;
      default: ;
    endcase

    pos_d = pos_q;
    if (bus.pos_clr) begin
      pos_d = '0;
    end else if (idx_rise_d) begin
      pos_d = '0;
    end else if (move_d) begin
      pos_d = fwd_d ? pos_q + N'(1) : pos_q - N'(1);
    end
  end

  // INIT/RUN sequencer with registered step/up/err/pos outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= 2'd0;
      prev_q     <= '0;
      step_q     <= 1'b0;
      up_q       <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          step_q <= 1'b0;
          if (bus.pos_clr) pos_q <= '0;
          if (bus.err_clr) err_q <= 1'b0;
          if (init_cnt_q == 2'd2) begin
            prev_q  <= s2_q;
            state_q <= S_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + 2'd1;
          end
        end
        S_RUN: begin
          prev_q <= f_q;
          step_q <= move_d;
          if (move_d) up_q <= fwd_d;
          pos_q  <= pos_d;
          err_q  <= ill_d | (err_q & ~bus.err_clr);
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.step = step_q;
  assign bus.up   = up_q;
  assign bus.err  = err_q;
  assign bus.pos  = pos_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - directed-vector bench for quadrature_decoder (index cases under QDEC_INDEX_EN)
module tb_quadrature_decoder;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   step_cnt = 0;
  int   base;

  always #5 clk = ~clk;

  quadrature_decoder_if #(.N(16)) bus ();

  quadrature_decoder #(.N(16), .FILT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Count step pulses on the falling edge, clear of the active edge.
  always @(negedge clk) if (bus.step === 1'b1) step_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input logic a, input logic b, input int hold);
    bus.a_in = a;
    bus.b_in = b;
    tick(hold);
  endtask

  initial begin
    reset       = 1'b1;
    bus.a_in    = 1'b0;
    bus.b_in    = 1'b0;
    bus.pos_clr = 1'b0;
    bus.err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
    bus.idx_in  = 1'b0;
`endif
    tick(3);
    check("rst_step", 32'(bus.step), 32'h0);
    check("rst_up",   32'(bus.up),   32'h0);
    check("rst_pos",  32'(bus.pos),  32'h0);
    check("rst_err",  32'(bus.err),  32'h0);
    reset = 1'b0;
    tick(8);
    check("init_pos", 32'(bus.pos), 32'h0);

    // Scenario 1: forward cycle with exact first-step latency
    base = step_cnt;
    bus.a_in = 1'b1;
    tick(5);
    check("lat_early_step", 32'(bus.step), 32'h0);
    tick(1);
    check("lat_step",  32'(bus.step), 32'h1);
    check("lat_up",    32'(bus.up),   32'h1);
    check("lat_pos",   32'(bus.pos),  32'h1);
    tick(1);
    check("lat_pulse_end", 32'(bus.step), 32'h0);
    tick(3);
    move(1'b1, 1'b1, 10);
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    check("fwd_steps", 32'(step_cnt - base), 32'd4);
    check("fwd_pos",   32'(bus.pos), 32'd4);
    check("fwd_up",    32'(bus.up),  32'h1);
    check("fwd_err",   32'(bus.err), 32'h0);

    // Scenario 2: wrap below zero and back
    bus.pos_clr = 1'b1;
    tick(1);
    bus.pos_clr = 1'b0;
    check("clr_pos", 32'(bus.pos), 32'h0);
    move(1'b0, 1'b1, 10);
    check("wrap_pos", 32'(bus.pos), 32'hFFFF);
    check("wrap_up",  32'(bus.up),  32'h0);
    move(1'b0, 1'b0, 10);
    check("unwrap_pos", 32'(bus.pos), 32'h0);
    check("unwrap_up",  32'(bus.up),  32'h1);

    // Scenario 3: short glitch rejected, minimum-width pulse accepted
    base = step_cnt;
    bus.a_in = 1'b1;
    tick(2);
    bus.a_in = 1'b0;
    tick(12);
    check("glitch_steps", 32'(step_cnt - base), 32'd0);
    check("glitch_pos",   32'(bus.pos), 32'h0);
    bus.a_in = 1'b1;
    tick(3);
    bus.a_in = 1'b0;
    tick(12);
    check("pulse_steps", 32'(step_cnt - base), 32'd2);
    check("pulse_pos",   32'(bus.pos), 32'h0);
    check("pulse_up",    32'(bus.up),  32'h0);

    // Scenario 4: illegal jumps, err stickiness and clear priority
    base = step_cnt;
    move(1'b1, 1'b1, 10);
    check("ill_steps", 32'(step_cnt - base), 32'd0);
    check("ill_err",   32'(bus.err), 32'h1);
    check("ill_pos",   32'(bus.pos), 32'h0);
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    tick(5);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("ill_clr_same_err", 32'(bus.err), 32'h1);
    tick(4);
    check("ill2_steps", 32'(step_cnt - base), 32'd0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("lone_clr_err", 32'(bus.err), 32'h0);

    // Scenario 5: reset with AB=11 held, then pos_clr against a step
    reset    = 1'b1;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    tick(3);
    base  = step_cnt;
    reset = 1'b0;
    tick(20);
    check("rst11_steps", 32'(step_cnt - base), 32'd0);
    check("rst11_err",   32'(bus.err), 32'h0);
    check("rst11_pos",   32'(bus.pos), 32'h0);
    move(1'b0, 1'b1, 10);
    check("rst11_fwd_pos", 32'(bus.pos), 32'h1);
    bus.b_in = 1'b0;
    tick(5);
    bus.pos_clr = 1'b1;
    tick(1);
    bus.pos_clr = 1'b0;
    check("clr_step_step", 32'(bus.step), 32'h1);
    check("clr_step_up",   32'(bus.up),   32'h1);
    check("clr_step_pos",  32'(bus.pos),  32'h0);
    tick(5);

`ifdef QDEC_INDEX_EN
    // Scenario 6: index rise coincident with a forward step
    move(1'b1, 1'b0, 10);
    move(1'b1, 1'b1, 10);
    move(1'b0, 1'b1, 10);
    move(1'b0, 1'b0, 10);
    move(1'b1, 1'b0, 10);
    move(1'b1, 1'b1, 10);
    move(1'b0, 1'b1, 10);
    check("idx_pre_pos", 32'(bus.pos), 32'd7);
    bus.b_in   = 1'b0;
    bus.idx_in = 1'b1;
    tick(6);
    check("idx_step", 32'(bus.step), 32'h1);
    check("idx_pos",  32'(bus.pos),  32'h0);
    tick(5);
    move(1'b1, 1'b0, 10);
    check("idx_held_pos", 32'(bus.pos), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter N, default 16: position counter width in bits.
REQ-002 Parameter FILT, default 3, legal range 1..15: consecutive stable samples required before a channel change is accepted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_in  input  1  quadrature channel A; asynchronous to clk.
REQ-006 b_in  input  1  quadrature channel B; asynchronous to clk.
REQ-007 pos_clr  input  1  synchronous clear of pos.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 step  output  1  one-cycle pulse per accepted quadrature transition; drives a counter enable.
REQ-010 up  output  1  direction of the current step: 1 = increment, 0 = decrement; drives a counter direction input.
REQ-011 pos  output  N  signed-agnostic position count, modulo 2^N.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 Each of a_in and b_in SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Per-channel filter: counter resets to 0 whenever sync2 equals the filtered value; on each mismatch sample it increments; on the FILT-th consecutive mismatch the filtered value SHALL take sync2 and the counter SHALL return to 0.
REQ-015 The FSM SHALL have 2 states. INIT (entered on reset): holds 2 cycles; on the 3rd edge it loads the filtered A/B values directly from sync2 without producing step or err, then moves to RUN. RUN: normal decoding; exits only on reset.
REQ-016 In RUN, the previous and new filtered {A,B} SHALL be compared every cycle. The sequence 00->10->11->01->00 SHALL give step=1, up=1. The reverse sequence SHALL give step=1, up=0. No change SHALL give step=0. A change in both bits SHALL give step=0 and set err.
REQ-017 step, up and err SHALL be registered outputs; step SHALL be high for exactly one cycle per accepted transition.
REQ-018 up SHALL hold its last value when step=0.
REQ-019 Latency: with a_in changed and stable before capture edge E0, step SHALL be high in the cycle following edge E0+FILT+2. For FILT=3, step is high after E5.
REQ-020 pos SHALL update in the same edge as step: +1 when up=1 and -1 when up=0, wrapping modulo 2^N (max+1 -> 0; 0-1 -> all ones).
REQ-021 Priority on pos: pos_clr > index clear (REQ-027) > step. A step coincident with a clear SHALL still pulse step/up, but pos SHALL become 0.
REQ-022 err SHALL remain 1 until err_clr. When err_clr and a new illegal transition occur in the same cycle, err SHALL remain 1.
REQ-023 Pulses shorter than FILT clk cycles after synchronization SHALL produce no step.

Reset
REQ-024 While reset=1 at a clock edge: pos=0, step=0, up=0, err=0, synchronizer flops=0, filtered values=0, filter counters=0, FSM=INIT.
REQ-025 A reset asserted mid-transition SHALL discard any partially filtered change. Decoding SHALL not resume until the INIT sequence completes again.

Configuration
REQ-026 Macro QDEC_INDEX_EN SHALL compile in the index feature. Without it, there SHALL be no index port and no index logic.
REQ-027 When QDEC_INDEX_EN is defined, the block SHALL add input idx_in (1 bit, asynchronous). idx_in SHALL be synchronized and filtered exactly as in REQ-013/REQ-014. A 0->1 change of the filtered index SHALL set pos to 0 on that edge. In INIT, the filtered index SHALL load from sync2 with no edge detection.

Verification
REQ-028 Scenario 1: FILT=3; after INIT, drive AB 00->10->11->01->00, each held 10 cycles -> 4 step pulses, up=1, pos=4, err=0; the first step is high after E5.
REQ-029 Scenario 2: from pos=0, drive the reverse sequence (one step) -> pos=0xFFFF (N=16) and up=0. Then drive the forward sequence (one step) -> pos=0x0000.
REQ-030 Scenario 3: a 2-cycle glitch on a_in with FILT=3 -> no step, pos unchanged. A 3-cycle pulse -> the change is accepted (step for the edge out, step for the edge back).
REQ-031 Scenario 4: AB 00->11 simultaneously -> step=0, err=1, pos unchanged. err_clr together with another 11->00 jump -> err stays 1. A lone err_clr -> err=0.
REQ-032 Scenario 5: reset with AB=11 held, release -> no step and no err during INIT or afterwards. pos_clr coincident with a forward step -> step=1, pos=0.
REQ-033 Scenario 6 (QDEC_INDEX_EN defined): pos=7, filtered idx rises in the same cycle as a forward step -> pos=0. Idx held high -> no further clears.
